// File: rtl/y86_pkg.sv
// Shared Y86 execute-stage definitions: ALU op encodings, jXX/cmovXX condition
// codes and the bit positions of {ZF,SF,OF} inside the condition-code vector.
package y86_pkg;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_XOR = 2'b11;

   localparam logic [3:0] C_ALWAYS = 4'd0;
   localparam logic [3:0] C_LE     = 4'd1;
   localparam logic [3:0] C_L      = 4'd2;
   localparam logic [3:0] C_E      = 4'd3;
   localparam logic [3:0] C_NE     = 4'd4;
   localparam logic [3:0] C_GE     = 4'd5;
   localparam logic [3:0] C_G      = 4'd6;

   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;

   typedef logic [2:0] cc_t;

   // Only arithmetic ops can overflow; logical ops always clear OF.
   function automatic logic of_for_op(input logic [1:0] ctrl, input logic of_in);
      logic of_r;
      case (ctrl)
         ALU_ADD: of_r = of_in;
         ALU_SUB: of_r = of_in;
         default: of_r = 1'b0;
      endcase
      return of_r;
   endfunction

endpackage

// File: rtl/cc_eval.sv
// Combinational jXX/cmovXX condition evaluator; also used by PC-select logic.
module cc_eval
   import y86_pkg::*;
(
   input  logic [3:0] ifun,
   input  logic       zf,
   input  logic       sf,
   input  logic       of,
   output logic       cnd,
   output logic       err
);

   logic lt_s;

   assign lt_s = sf ^ of;

   // Decode the condition; unknown codes never take the branch and raise err.
   always_comb begin
      cnd = 1'b0;
      err = 1'b0;
      case (ifun)
         C_ALWAYS: cnd = 1'b1;
         C_LE:     cnd = lt_s | zf;
         C_L:      cnd = lt_s;
         C_E:      cnd = zf;
         C_NE:     cnd = ~zf;
         C_GE:     cnd = ~lt_s;
         C_G:      cnd = ~lt_s & ~zf;
         default: begin
            cnd = 1'b0;
            err = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/cc_unit.sv
// Condition-code register plus registered branch/cmov condition result for the
// SEQ execute stage; BYPASS lets a same-cycle CC update feed the evaluation.
module cc_unit
   import y86_pkg::*;
#(
   parameter int WIDTH    = 64,
   parameter bit BYPASS   = 1'b1,
   parameter bit RESET_ZF = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             res_valid,
   output logic             res_ready,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_of,
   input  logic [1:0]       alu_ctrl,
   input  logic             set_cc,
   input  logic             stall,
   input  logic             bubble,
   input  logic             cond_valid,
   input  logic [3:0]       ifun,
   output logic             cnd,
   output logic             cnd_valid,
   output logic             cnd_err,
   output logic [2:0]       cc_out
);

   cc_t  cc_q, cc_d, cc_new_s, flags_s;
   logic cc_upd_s, req_s;
   logic eval_cnd_s, eval_err_s;
   logic cnd_q, cnd_d, cnd_valid_q, cnd_valid_d, cnd_err_q, cnd_err_d;

   assign res_ready = ~stall;
   assign cc_upd_s  = res_valid & ~stall & ~bubble & set_cc;
   assign req_s     = cond_valid & ~stall & ~bubble;

   // Candidate flags from the incoming result and the flags the evaluator sees.
   always_comb begin
      cc_new_s        = 3'b000;
      cc_new_s[CC_ZF] = (alu_out == {WIDTH{1'b0}});
      cc_new_s[CC_SF] = alu_out[WIDTH-1];
      cc_new_s[CC_OF] = of_for_op(alu_ctrl, alu_of);
      if (cc_upd_s) begin
         cc_d = cc_new_s;
      end else begin
         cc_d = cc_q;
      end
      if (BYPASS && cc_upd_s) begin
         flags_s = cc_new_s;
      end else begin
         flags_s = cc_q;
      end
   end

   cc_eval u_eval (
      .ifun (ifun),
      .zf   (flags_s[CC_ZF]),
      .sf   (flags_s[CC_SF]),
      .of   (flags_s[CC_OF]),
      .cnd  (eval_cnd_s),
      .err  (eval_err_s)
   );

   // Result registers: load on an accepted request, hold otherwise.
   always_comb begin
      cnd_valid_d = cnd_valid_q;
      cnd_d       = cnd_q;
      cnd_err_d   = cnd_err_q;
      if (!stall) begin
         cnd_valid_d = req_s;
      end else begin
         cnd_valid_d = cnd_valid_q;
      end
      if (req_s) begin
         cnd_d     = eval_cnd_s;
         cnd_err_d = eval_err_s;
      end else begin
         cnd_d     = cnd_q;
         cnd_err_d = cnd_err_q;
      end
   end

   // State update with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cc_q        <= {RESET_ZF, 2'b00};
         cnd_q       <= 1'b0;
         cnd_valid_q <= 1'b0;
         cnd_err_q   <= 1'b0;
      end else begin
         cc_q        <= cc_d;
         cnd_q       <= cnd_d;
         cnd_valid_q <= cnd_valid_d;
         cnd_err_q   <= cnd_err_d;
      end
   end

   assign cc_out    = cc_q;
   assign cnd       = cnd_q;
   assign cnd_valid = cnd_valid_q;
   assign cnd_err   = cnd_err_q;

endmodule

// File: tb/tb_cc_unit.sv
// Directed self-checking bench for cc_unit; a BYPASS=0 copy shares the inputs
// so both flag-selection behaviours are compared on the same vectors.
module tb_cc_unit;
   import y86_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        res_valid, alu_of, set_cc, stall, bubble, cond_valid;
   logic [63:0] alu_out;
   logic [1:0]  alu_ctrl;
   logic [3:0]  ifun;
   logic        res_ready, cnd, cnd_valid, cnd_err;
   logic [2:0]  cc_out;
   logic        nb_res_ready, nb_cnd, nb_cnd_valid, nb_cnd_err;
   logic [2:0]  nb_cc_out;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   cc_unit #(.WIDTH(64), .BYPASS(1'b1), .RESET_ZF(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_ready(res_ready),
      .alu_out(alu_out), .alu_of(alu_of), .alu_ctrl(alu_ctrl), .set_cc(set_cc),
      .stall(stall), .bubble(bubble), .cond_valid(cond_valid), .ifun(ifun),
      .cnd(cnd), .cnd_valid(cnd_valid), .cnd_err(cnd_err), .cc_out(cc_out));

   cc_unit #(.WIDTH(64), .BYPASS(1'b0), .RESET_ZF(1'b1)) dut_nb (
      .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_ready(nb_res_ready),
      .alu_out(alu_out), .alu_of(alu_of), .alu_ctrl(alu_ctrl), .set_cc(set_cc),
      .stall(stall), .bubble(bubble), .cond_valid(cond_valid), .ifun(ifun),
      .cnd(nb_cnd), .cnd_valid(nb_cnd_valid), .cnd_err(nb_cnd_err), .cc_out(nb_cc_out));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      res_valid = 1'b0; set_cc = 1'b0; cond_valid = 1'b0;
      stall = 1'b0; bubble = 1'b0; alu_of = 1'b0;
      alu_ctrl = ALU_ADD; alu_out = 64'd0; ifun = 4'd0;
   endtask

   task automatic result(input logic [63:0] o, input logic [1:0] ctrl, input logic of, input logic sc);
      res_valid = 1'b1; alu_out = o; alu_ctrl = ctrl; alu_of = of; set_cc = sc;
   endtask

   task automatic request(input logic [3:0] f);
      cond_valid = 1'b1; ifun = f;
   endtask

   task automatic expect_out(input string tag, input logic c, input logic v, input logic e);
      check({tag, "_cnd"}, {63'd0, cnd}, {63'd0, c});
      check({tag, "_valid"}, {63'd0, cnd_valid}, {63'd0, v});
      check({tag, "_err"}, {63'd0, cnd_err}, {63'd0, e});
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      #12;
      rst_n = 1'b1;
      tick();
      check("reset_cc", {61'd0, cc_out}, 64'd4);
      expect_out("reset", 1'b0, 1'b0, 1'b0);

      // 1: perturb state, then asynchronous reset mid-cycle
      result(64'hFFFF_FFFF_FFFF_FFFF, ALU_SUB, 1'b0, 1'b1);
      request(C_ALWAYS);
      tick();
      idle();
      check("pre_rst_cc", {61'd0, cc_out}, 64'd2);
      check("pre_rst_valid", {63'd0, cnd_valid}, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_cc", {61'd0, cc_out}, 64'd4);
      check("async_rst_valid", {63'd0, cnd_valid}, 64'd0);
      check("async_rst_cnd", {63'd0, cnd}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // 2: sub 5-5 -> ZF
      result(64'd0, ALU_SUB, 1'b0, 1'b1);
      tick();
      idle();
      check("sub0_cc", {61'd0, cc_out}, 64'd4);
      request(C_E);
      tick();
      idle();
      expect_out("e_after_sub", 1'b1, 1'b1, 1'b0);
      tick();
      check("valid_drops", {63'd0, cnd_valid}, 64'd0);
      check("cnd_holds", {63'd0, cnd}, 64'd1);

      // 3: signed overflow to most-negative
      result(64'h8000_0000_0000_0000, ALU_ADD, 1'b1, 1'b1);
      tick();
      idle();
      check("ovf_cc", {61'd0, cc_out}, 64'd3);
      request(C_L);
      tick();
      expect_out("l_ovf", 1'b0, 1'b1, 1'b0);
      request(C_GE);
      tick();
      expect_out("ge_ovf", 1'b1, 1'b1, 1'b0);
      request(C_LE);
      tick();
      expect_out("le_ovf", 1'b0, 1'b1, 1'b0);
      idle();

      // 4: xor clears OF even with alu_of high; no set_cc / no valid -> no change
      result(64'h8000_0000_0000_0000, ALU_XOR, 1'b1, 1'b1);
      tick();
      check("xor_cc", {61'd0, cc_out}, 64'd2);
      result(64'd0, ALU_ADD, 1'b1, 1'b0);
      tick();
      check("no_setcc_cc", {61'd0, cc_out}, 64'd2);
      result(64'd0, ALU_SUB, 1'b1, 1'b1);
      res_valid = 1'b0;
      tick();
      check("no_valid_cc", {61'd0, cc_out}, 64'd2);
      result(64'h0000_0000_0000_00F0, ALU_AND, 1'b1, 1'b1);
      tick();
      check("and_cc", {61'd0, cc_out}, 64'd0);
      result(64'h8000_0000_0000_0000, ALU_XOR, 1'b0, 1'b1);
      tick();
      idle();
      check("xor_neg_cc", {61'd0, cc_out}, 64'd2);

      // 5: same-cycle update (result 0) with ne request
      result(64'd0, ALU_SUB, 1'b0, 1'b1);
      request(C_NE);
      tick();
      idle();
      check("byp_cnd", {63'd0, cnd}, 64'd0);
      check("nobyp_cnd", {63'd0, nb_cnd}, 64'd1);
      check("byp_cc", {61'd0, cc_out}, 64'd4);
      check("nobyp_cc", {61'd0, nb_cc_out}, 64'd4);

      // 6: stall freezes everything
      request(C_ALWAYS);
      tick();
      expect_out("pre_stall", 1'b1, 1'b1, 1'b0);
      stall = 1'b1;
      bubble = 1'b1;
      request(4'd9);
      result(64'h0000_0000_0000_0005, ALU_ADD, 1'b1, 1'b1);
      #1;
      check("stall_ready", {63'd0, res_ready}, 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_out("stall", 1'b1, 1'b1, 1'b0);
         check("stall_cc", {61'd0, cc_out}, 64'd4);
      end
      stall = 1'b0;
      #1;
      check("bubble_ready", {63'd0, res_ready}, 64'd1);
      tick();
      check("bubble_valid", {63'd0, cnd_valid}, 64'd0);
      check("bubble_cc", {61'd0, cc_out}, 64'd4);
      idle();
      request(4'd9);
      tick();
      expect_out("ifun9", 1'b0, 1'b1, 1'b1);
      request(4'd15);
      tick();
      expect_out("ifun15", 1'b0, 1'b1, 1'b1);
      request(C_G);
      tick();
      expect_out("g_zf", 1'b0, 1'b1, 1'b0);
      idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
